lwc_post_processor: RTL and testbench

- Downstream neighbour of the SpoC-64 crypto core; consumes its bdo/tag/msg_auth stream and produces the LWC public output stream (do_*).
- Rebuilds the output segment headers from instruction/header words forwarded by the pre-processor on the cmd channel.
- Inserts the tag segment (encrypt) and the final status word (encrypt and decrypt).
- One 32-bit word per do_valid&do_ready cycle.

---
 rtl/lwc_pp_pkg.sv | 41 ++++
 rtl/lwc_post_processor.sv | 198 +++++++++++++++++++
 tb/tb_lwc_post_processor.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lwc_pp_pkg.sv
// Shared constants, FSM state encoding and byte-mask helper for lwc_post_processor.
package lwc_pp_pkg;

  localparam logic [3:0] OP_ENC   = 4'h2;
  localparam logic [3:0] OP_DEC   = 4'h3;
  localparam logic [3:0] TYPE_PT  = 4'h4;
  localparam logic [3:0] TYPE_CT  = 4'h5;
  localparam logic [3:0] TYPE_TAG = 4'h8;

  localparam logic [31:0] STATUS_SUCCESS = 32'hE000_0000;
  localparam logic [31:0] STATUS_FAILURE = 32'hF000_0000;

  localparam int HDR_TYPE_MSB = 31;
  localparam int HDR_TYPE_LSB = 28;
  localparam int HDR_EOI      = 26;
  localparam int HDR_EOT      = 25;
  localparam int HDR_LAST     = 24;
  localparam int HDR_LEN_MSB  = 15;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_HDR    = 3'd1,
    ST_WR_HDR    = 3'd2,
    ST_DATA      = 3'd3,
    ST_TAG_HDR   = 3'd4,
    ST_TAG       = 3'd5,
    ST_WAIT_AUTH = 3'd6,
    ST_STATUS    = 3'd7
  } pp_state_e;

  // vb[3] qualifies the most significant byte, vb[0] the least significant one.
  function automatic logic [31:0] byte_mask(input logic [31:0] data, input logic [3:0] vb);
    logic [31:0] res;
    res = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = vb[i] ? data[8*i +: 8] : 8'h00;
    end
    return res;
  endfunction

endpackage

// File: rtl/lwc_post_processor.sv
// LWC post-processor: rebuilds output headers, forwards core data/tag, appends status.
// Build option: define LWC_PP_BYTE_MASK_EN to zero invalid bytes of data words.
module lwc_post_processor
  import lwc_pp_pkg::*;
#(
  parameter int W         = 32,
  parameter int TAG_WORDS = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] cmd,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] bdo,
  input  logic         bdo_valid,
  output logic         bdo_ready,
  input  logic [3:0]   bdo_valid_bytes,
  input  logic         end_of_block,
  input  logic         msg_auth,
  input  logic         msg_auth_valid,
  output logic         msg_auth_ready,
  output logic [W-1:0] do_data,
  output logic         do_valid,
  input  logic         do_ready,
  output logic         do_last
);

  localparam int          TCW       = (TAG_WORDS > 1) ? $clog2(TAG_WORDS) : 1;
  localparam logic [15:0] TAG_BYTES = 16'(TAG_WORDS * 4);

  pp_state_e      state_q, state_d;
  logic           enc_q, enc_d;
  logic           auth_q, auth_d;
  logic           active_q;
  logic [27:0]    hdr_q, hdr_d;
  logic [15:0]    len_q, len_d;
  logic [TCW-1:0] tag_cnt_q, tag_cnt_d;

  logic [W-1:0]   wr_hdr_s;
  logic [W-1:0]   tag_hdr_s;
  logic [W-1:0]   data_out_s;
  logic           bdo_fire_s;
  pp_state_e      after_data_s;

  assign wr_hdr_s = {(enc_q ? TYPE_CT : TYPE_PT), hdr_q[27], hdr_q[HDR_EOI] & ~enc_q,
                     hdr_q[HDR_EOT], hdr_q[HDR_LAST] & ~enc_q, hdr_q[23:0]};
  assign tag_hdr_s  = {TYPE_TAG, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, TAG_BYTES};
  assign bdo_fire_s = bdo_valid & do_ready;
  assign after_data_s = enc_q ? ST_TAG_HDR : ST_WAIT_AUTH;

`ifdef LWC_PP_BYTE_MASK_EN
  assign data_out_s = byte_mask(bdo, bdo_valid_bytes);
  logic unused_s;
  assign unused_s = end_of_block;
`else
  assign data_out_s = bdo;
  logic unused_s;
  assign unused_s = ^{end_of_block, bdo_valid_bytes};
`endif

  // active_q keeps every ready low for the first cycle after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      enc_q     <= 1'b0;
      auth_q    <= 1'b0;
      active_q  <= 1'b0;
      hdr_q     <= 28'h0;
      len_q     <= 16'h0;
      tag_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      enc_q     <= enc_d;
      auth_q    <= auth_d;
      active_q  <= 1'b1;
      hdr_q     <= hdr_d;
      len_q     <= len_d;
      tag_cnt_q <= tag_cnt_d;
    end
  end

  // Next-state, counters and output mux.
  always_comb begin
    state_d        = state_q;
    enc_d          = enc_q;
    auth_d         = auth_q;
    hdr_d          = hdr_q;
    len_d          = len_q;
    tag_cnt_d      = tag_cnt_q;
    cmd_ready      = 1'b0;
    bdo_ready      = 1'b0;
    msg_auth_ready = 1'b0;
    do_valid       = 1'b0;
    do_last        = 1'b0;
    do_data        = '0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = active_q;
        if (cmd_valid && active_q) begin
          if (cmd[HDR_TYPE_MSB:HDR_TYPE_LSB] == OP_ENC) begin
            enc_d   = 1'b1;
            state_d = ST_RD_HDR;
          end else if (cmd[HDR_TYPE_MSB:HDR_TYPE_LSB] == OP_DEC) begin
            enc_d   = 1'b0;
            state_d = ST_RD_HDR;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_HDR: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          hdr_d   = cmd[27:0];
          len_d   = cmd[HDR_LEN_MSB:0];
          state_d = ST_WR_HDR;
        end else begin
          state_d = ST_RD_HDR;
        end
      end
      ST_WR_HDR: begin
        do_valid = 1'b1;
        do_data  = wr_hdr_s;
        if (do_ready) begin
          state_d = (len_q != 16'h0) ? ST_DATA : after_data_s;
        end else begin
          state_d = ST_WR_HDR;
        end
      end
      ST_DATA: begin
        bdo_ready = do_ready;
        do_valid  = bdo_valid;
        do_data   = data_out_s;
        // Short final word: counter saturates at zero instead of wrapping.
        if (bdo_fire_s) begin
          if (len_q <= 16'd4) begin
            len_d   = 16'h0;
            state_d = after_data_s;
          end else begin
            len_d   = len_q - 16'd4;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_TAG_HDR: begin
        do_valid = 1'b1;
        do_data  = tag_hdr_s;
        if (do_ready) begin
          tag_cnt_d = '0;
          state_d   = ST_TAG;
        end else begin
          state_d   = ST_TAG_HDR;
        end
      end
      ST_TAG: begin
        bdo_ready = do_ready;
        do_valid  = bdo_valid;
        do_data   = bdo;
        if (bdo_fire_s) begin
          if (tag_cnt_q == TCW'(TAG_WORDS - 1)) begin
            tag_cnt_d = '0;
            state_d   = ST_STATUS;
          end else begin
            tag_cnt_d = tag_cnt_q + TCW'(1);
          end
        end else begin
          state_d = ST_TAG;
        end
      end
      ST_WAIT_AUTH: begin
        msg_auth_ready = 1'b1;
        if (msg_auth_valid) begin
          auth_d  = msg_auth;
          state_d = ST_STATUS;
        end else begin
          state_d = ST_WAIT_AUTH;
        end
      end
      ST_STATUS: begin
        do_valid = 1'b1;
        do_last  = 1'b1;
        do_data  = (enc_q || auth_q) ? STATUS_SUCCESS : STATUS_FAILURE;
        if (do_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STATUS;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lwc_post_processor.sv
// Table-driven, scoreboard-based bench for lwc_post_processor.
module tb_lwc_post_processor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cmd = 32'h0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] bdo = 32'h0;
  logic        bdo_valid = 1'b0;
  logic        bdo_ready;
  logic [3:0]  bdo_valid_bytes = 4'h0;
  logic        end_of_block = 1'b0;
  logic        msg_auth = 1'b0;
  logic        msg_auth_valid = 1'b0;
  logic        msg_auth_ready;
  logic [31:0] do_data;
  logic        do_valid;
  logic        do_ready = 1'b0;
  logic        do_last;

  always #5 clk = ~clk;

  lwc_post_processor #(.W(32), .TAG_WORDS(2)) dut (
    .clk(clk), .rst(rst),
    .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .bdo(bdo), .bdo_valid(bdo_valid), .bdo_ready(bdo_ready),
    .bdo_valid_bytes(bdo_valid_bytes), .end_of_block(end_of_block),
    .msg_auth(msg_auth), .msg_auth_valid(msg_auth_valid), .msg_auth_ready(msg_auth_ready),
    .do_data(do_data), .do_valid(do_valid), .do_ready(do_ready), .do_last(do_last)
  );

  typedef struct packed { logic [31:0] data; logic last; } out_t;
  typedef struct packed { logic [31:0] d; logic [3:0] m; } bw_t;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] hdr, w0, w1, t0, t1;
    logic        auth;
    bit          stall;
  } vec_t;

  out_t        exp_q[$];
  logic [31:0] cmd_src[$];
  bw_t         bdo_src[$];
  logic        auth_src[$];

  int  n_vec = 0;
  int  n_err = 0;
  int  bdo_hs_cnt = 0;
  int  out_cnt = 0;
  bit  stall_en = 1'b0;
  bit  cmd_hs = 1'b0, bdo_hs = 1'b0, auth_hs = 1'b0;
  bit  prev_stall = 1'b0;
  logic [31:0] prev_data = 32'h0;
  vec_t vt[7];

  function automatic logic [31:0] exp_data(input logic [31:0] d, input logic [3:0] m);
`ifdef LWC_PP_BYTE_MASK_EN
    return d & {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
`else
    return d | {28'h0, 4'h0 & m};
`endif
  endfunction

  // Source driver: retire handshaken words, present the next ones.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cmd_hs && cmd_src.size() > 0) void'(cmd_src.pop_front());
      if (bdo_hs && bdo_src.size() > 0) begin
        void'(bdo_src.pop_front());
        bdo_hs_cnt++;
      end
      if (auth_hs && auth_src.size() > 0) void'(auth_src.pop_front());
      cmd_valid       = (cmd_src.size() > 0);
      cmd             = cmd_valid ? cmd_src[0] : 32'h0;
      bdo_valid       = (bdo_src.size() > 0);
      bdo             = bdo_valid ? bdo_src[0].d : 32'h0;
      bdo_valid_bytes = bdo_valid ? bdo_src[0].m : 4'h0;
      msg_auth_valid  = (auth_src.size() > 0);
      msg_auth        = msg_auth_valid ? auth_src[0] : 1'b0;
      do_ready        = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard compare and hold-stability check.
  initial begin
    out_t e;
    forever begin
      @(negedge clk);
      cmd_hs  = !rst && cmd_valid && cmd_ready;
      bdo_hs  = !rst && bdo_valid && bdo_ready;
      auth_hs = !rst && msg_auth_valid && msg_auth_ready;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          n_vec++;
          if (!(do_valid && do_data == prev_data)) begin
            n_err++;
            $display("FAIL hold_stable got valid %b data %h, required valid 1 data %h",
                     do_valid, do_data, prev_data);
          end
        end
        if (do_valid && do_ready) begin
          n_vec++;
          out_cnt++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_out got %h/last %b, required no output", do_data, do_last);
          end else begin
            e = exp_q.pop_front();
            if (do_data !== e.data || do_last !== e.last) begin
              n_err++;
              $display("FAIL do_word got %h/last %b, required %h/last %b",
                       do_data, do_last, e.data, e.last);
            end
          end
        end
        prev_stall = do_valid && !do_ready;
        prev_data  = do_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic flush();
    exp_q.delete();
    cmd_src.delete();
    bdo_src.delete();
    auth_src.delete();
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s got %h, required %h", name, got, req);
    end
  endtask

  function automatic int n_words(input vec_t v);
    return (int'(v.hdr[15:0]) + 3) / 4;
  endfunction

  task automatic push_vec(input vec_t v);
    int          len;
    int          r;
    bit          enc;
    logic [3:0]  fl;
    logic [3:0]  m;
    logic [31:0] d;
    enc = (v.op == 4'h2);
    len = int'(v.hdr[15:0]);
    cmd_src.push_back({v.op, 28'h0});
    cmd_src.push_back(v.hdr);
    fl = enc ? (v.hdr[27:24] & 4'b1010) : v.hdr[27:24];
    exp_q.push_back({{(enc ? 4'h5 : 4'h4), fl, v.hdr[23:0]}, 1'b0});
    for (int k = 0; k < n_words(v); k++) begin
      d = (k == 0) ? v.w0 : (k == 1) ? v.w1 : (v.w1 ^ {4{8'(k)}});
      r = len - 4 * k;
      m = (r >= 4) ? 4'hF : 4'(4'hF << (4 - r));
      bdo_src.push_back({d, m});
      exp_q.push_back({exp_data(d, m), 1'b0});
    end
    if (enc) begin
      exp_q.push_back({32'h8700_0008, 1'b0});
      bdo_src.push_back({v.t0, 4'h0});
      exp_q.push_back({v.t0, 1'b0});
      bdo_src.push_back({v.t1, 4'h0});
      exp_q.push_back({v.t1, 1'b0});
      exp_q.push_back({32'hE000_0000, 1'b1});
    end else begin
      auth_src.push_back(v.auth);
      exp_q.push_back({(v.auth ? 32'hE000_0000 : 32'hF000_0000), 1'b1});
    end
  endtask

  task automatic wait_done(input string name);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 3000) begin
      tick();
      c++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_timeout got %0d outputs pending, required 0", name, exp_q.size());
      flush();
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int base;
    base = bdo_hs_cnt;
    stall_en = v.stall;
    push_vec(v);
    wait_done(name);
    tick();
    check({name, "_bdo_used"}, 32'(bdo_hs_cnt - base), 32'(n_words(v) + ((v.op == 4'h2) ? 2 : 0)));
    check({name, "_src_left"}, 32'(cmd_src.size() + bdo_src.size() + auth_src.size()), 32'h0);
    stall_en = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_outs"}, {26'h0, do_valid, do_last, cmd_ready, bdo_ready, msg_auth_ready, 1'b0}, 32'h0);
    check({name, "_do_data"}, do_data, 32'h0);
  endtask

  initial begin
    int c;
    int base;
    int oc;
    vt[0] = '{4'h2, 32'h4700_0005, 32'hAABB_CCDD, 32'h1122_3344, 32'h0102_0304, 32'h0506_0708, 1'b0, 1'b0};
    vt[1] = '{4'h3, 32'h4700_0008, 32'h0BAD_F00D, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 1'b0};
    vt[2] = '{4'h3, 32'h4700_0008, 32'hCAFE_BABE, 32'h8765_4321, 32'h0, 32'h0, 1'b1, 1'b0};
    vt[3] = '{4'h2, 32'h4700_0000, 32'h0, 32'h0, 32'hA1A2_A3A4, 32'hB1B2_B3B4, 1'b0, 1'b0};
    vt[4] = '{4'h2, 32'h4700_0005, 32'hAABB_CCDD, 32'h1122_3344, 32'h0102_0304, 32'h0506_0708, 1'b0, 1'b1};
    vt[5] = '{4'h3, 32'h4300_000B, 32'hDEAD_BEEF, 32'h5566_7788, 32'h0, 32'h0, 1'b1, 1'b1};
    vt[6] = '{4'h2, 32'h4100_0004, 32'h1357_9BDF, 32'h0, 32'h9988_7766, 32'h4433_2211, 1'b0, 1'b0};

    rst = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check("idle_cmd_ready", {31'h0, cmd_ready}, 32'h1);

    for (int i = 0; i < 7; i++) begin
      run_vec(vt[i], $sformatf("vec%0d", i));
    end

    // Unknown opcode is swallowed without output.
    oc = out_cnt;
    cmd_src.push_back(32'h7000_0000);
    repeat (6) tick();
    check("badop_consumed", 32'(cmd_src.size()), 32'h0);
    check("badop_no_output", 32'(out_cnt - oc), 32'h0);
    run_vec(vt[6], "after_badop");

    // Reset while the third data word of a 16-byte decrypt is on the bus.
    base = bdo_hs_cnt;
    push_vec('{4'h3, 32'h4700_0010, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h0, 32'h0, 1'b1, 1'b0});
    c = 0;
    while (bdo_hs_cnt < base + 2 && c < 200) begin
      tick();
      c++;
    end
    check("rst_reach_word3", 32'(bdo_hs_cnt - base), 32'h2);
    rst = 1'b1;
    flush();
    tick();
    check_all_zero("midrst");
    rst = 1'b0;
    tick();
    check("midrst_idle", {30'h0, cmd_ready, do_valid}, 32'h2);
    run_vec(vt[6], "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
